subn_serial: RTL

SUBN_SERIAL -- requirements
Module: subn_serial

---
 rtl/subn_serial.sv | 135 +++++++++++++
 1 files changed

// File: rtl/subn_serial.sv
// subn_serial: bit-serial subtractor computing a - b - bin one bit per cycle, LSB first.
// Handshake: operands are accepted in IDLE on in_valid && in_ready. Results are held in DONE
// until out_ready is seen.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   a, b, bin, in_valid - operands, borrow-in and their valid strobe
//   in_ready            - high only in IDLE
//   diff, bout, ovf     - difference mod 2^WIDTH, unsigned borrow-out, signed overflow
//   out_valid           - high only in DONE
//   out_ready           - consumer accepts the result
module subn_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_last;
    logic               w_ai;
    logic               w_bi;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res_next;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // Full-subtractor slice on the current LSBs of the shifted operands
    assign w_ai       = r_a[0];
    assign w_bi       = r_b[0];
    assign w_d        = w_ai ^ w_bi ^ r_br;
    assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they track r_state exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
        end
    end

    // Serial datapath; on the last bit r_a[0]/r_b[0] are the original sign bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_br_next;
                r_ovf  <= (w_ai != w_bi) && (w_d != w_ai);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule
